addsub_seq: RTL and testbench

Parametrised, multi-cycle add/subtract unit for the ALU datapath. It is the sequential successor to the fixed 8-bit ripple subtractor. Width is generic and selectable at elaboration. The operation (add or subtract) is chosen per transaction. The datapath processes CHUNK bits per clock through a narrow ripple slice, which bounds the carry path. Operands arrive and results leave over valid/ready handshakes. The result carries Cout, Ovf, Zero and Neg status flags for the ALU flag register.

---
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_seq.sv | 132 +++++++++++++
 tb/tb_addsub_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
// The producer/consumer side uses master; the unit uses slave.
interface addsub_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: sums CHUNK bits per clock through a narrow ripple slice,
// with valid/ready handshakes on both sides and ALU status flags on the result.
module addsub_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  addsub_seq_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SLW    = CHUNK + 1;

  generate
    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic in_ready_c, accept_c, step_c, load_c, last_c;

  logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, acc_d;
  logic             carry_q, a_msb_q, b_msb_q;
  logic [IDXW-1:0]  idx_q;
  logic [CHUNK:0]   slice_c;
  logic [WIDTH-1:0] op_b_in_c;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q, neg_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = BUSY;
      BUSY:    if (last_c)       state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    in_ready_c = 1'b0;
    step_c     = 1'b0;
    accept_c   = 1'b0;
    load_c     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        accept_c   = bus.in_valid;
      end
      BUSY: begin
        step_c = 1'b1;
        load_c = last_c;
      end
      default: ;
    endcase
  end

  // Ripple slice over the low chunk; operands shift down so the active chunk is always at bit 0
  assign last_c    = (idx_q == IDXW'(NCHUNK - 1));
  assign slice_c   = {1'b0, op_a_q[CHUNK-1:0]} + {1'b0, op_b_q[CHUNK-1:0]} + SLW'(carry_q);
  assign acc_d     = WIDTH'({slice_c[CHUNK-1:0], acc_q} >> CHUNK);
  assign op_b_in_c = bus.sub ? ~bus.b : bus.b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept_c) begin
      op_a_q  <= bus.a;
      op_b_q  <= op_b_in_c;
      carry_q <= bus.sub;
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= op_b_in_c[WIDTH-1];
      idx_q   <= '0;
    end else if (step_c) begin
      op_a_q  <= op_a_q >> CHUNK;
      op_b_q  <= op_b_q >> CHUNK;
      acc_q   <= acc_d;
      carry_q <= slice_c[CHUNK];
      idx_q   <= idx_q + IDXW'(1);
    end
  end

  // Result and flags load only on DONE entry and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      out_valid_q <= (state_d == DONE);
      if (load_c) begin
        sum_q  <= acc_d;
        cout_q <= slice_c[CHUNK];
        ovf_q  <= (a_msb_q == b_msb_q) & (acc_d[WIDTH-1] != a_msb_q);
        zero_q <= ~|acc_d;
        neg_q  <= acc_d[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed corner cases plus randomized traffic
// on a 16/4 instance and a single-chunk 8/8 instance, checked against an arithmetic model.
module tb_addsub_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done8 = 1'b0;

  always #5 clk = ~clk;

  addsub_seq_if #(.WIDTH(16)) bus ();
  addsub_seq_if #(.WIDTH(8))  bus8 ();

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  addsub_seq #(.WIDTH(8),  .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  // Directed table: operands, op, expected sum, expected {cout, ovf, zero, neg}
  logic [15:0] d_a [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
  logic [15:0] d_b [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
  logic        d_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] d_r [6] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
  logic [3:0]  d_f [6] = '{4'b0000, 4'b1010, 4'b0101, 4'b0001, 4'b1100, 4'b1010};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic logic [35:0] model(input int w, input logic [31:0] ua, input logic [31:0] ub,
                                        input logic sub);
    longint m, a, b, sa, sb, full, sres, s;
    logic c, v, z, n;
    m  = longint'(1) << w;
    a  = longint'(ua);
    b  = longint'(ub);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      full = a - b;
      c    = (a >= b);
      sres = sa - sb;
    end else begin
      full = a + b;
      c    = (full >= m);
      sres = sa + sb;
    end
    s = ((full % m) + m) % m;
    v = (sres < -(m / 2)) || (sres >= m / 2);
    z = (s == 0);
    n = (s >= m / 2);
    return {c, v, z, n, 32'(s)};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One full transaction on the 16/4 unit, with `hold` cycles of output backpressure
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       input logic [15:0] es, input logic [3:0] ef, input int hold);
    int cnt;
    bus.a = ta;
    bus.b = tb;
    bus.sub = ts;
    bus.in_valid = 1'b1;
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.sub = 1'($urandom);
    chk("in_ready_busy", 64'(bus.in_ready), 64'(0));
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    bus.out_ready = 1'b0;
    chk("latency", 64'(cnt), 64'(4));
    chk("sum", 64'(bus.sum), 64'(es));
    chk("flags", 64'({bus.cout, bus.ovf, bus.zero, bus.neg}), 64'(ef));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_ready", 64'(bus.in_ready), 64'(0));
      chk("hold_sum", 64'({bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg}), 64'({es, ef}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("drain_valid", 64'(bus.out_valid), 64'(0));
    chk("drain_ready", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [35:0] r;
    logic [15:0] ra, rb;
    logic        rs;
    int          cnt;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 16'hA5A5;
    bus.b = 16'h5A5A;
    bus.sub = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_sum", 64'({bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_op(d_a[i], d_b[i], d_s[i], d_r[i], d_f[i], (i == 0) ? 5 : 0);

    for (int i = 0; i < 300; i++) begin
      ra = rnd16();
      rb = rnd16();
      rs = 1'($urandom);
      r  = model(16, 32'(ra), 32'(rb), rs);
      do_op(ra, rb, rs, r[15:0], r[35:32], $urandom_range(0, 2));
    end

    // Make the held result non-zero so the reset clear is observable
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101, 0);
    bus.a = 16'hFFF0;
    bus.b = 16'h0123;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_ready", 64'(bus.in_ready), 64'(1));
    chk("abort_sum", 64'({bus.sum, bus.cout, bus.ovf, bus.zero, bus.neg}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 0);

    cnt = 0;
    while (!done8 && cnt < 5000) begin
      @(posedge clk);
      cnt++;
    end
    chk("w8_done", 64'(done8), 64'(1));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Single-chunk instance: behaves as a one-cycle registered adder
  initial begin
    logic [35:0] r;
    logic [7:0]  a8, b8;
    logic        s8;
    int          cnt;
    rst8_n = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = 1'($urandom);
      r  = model(8, 32'(a8), 32'(b8), s8);
      bus8.a = a8;
      bus8.b = b8;
      bus8.sub = s8;
      bus8.in_valid = 1'b1;
      chk("w8_in_ready", 64'(bus8.in_ready), 64'(1));
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      cnt = 0;
      while (!bus8.out_valid && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("w8_latency", 64'(cnt), 64'(1));
      chk("w8_sum", 64'(bus8.sum), 64'(r[7:0]));
      chk("w8_flags", 64'({bus8.cout, bus8.ovf, bus8.zero, bus8.neg}), 64'(r[35:32]));
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      chk("w8_drain", 64'(bus8.out_valid), 64'(0));
    end
    done8 = 1'b1;
  end
endmodule
